pipe_trace_monitor: RTL and testbench
=====================================

// Module: pipe_trace_monitor
// PURPOSE
//  Synthesizable trace/halt monitor for the AK-16 pipeline, parametrised in stage count, buffer depth and capture mode.
//  Snoops per-stage pipeline state each cycle into a circular trace RAM. Detects HALT, drains the remaining stages
//  and flags completion, or flags a watchdog timeout. Sits beside cpu_top_pipeline; the buffer is read out after DONE.
// PARAMETERS
//  STAGES       6     pipeline stages (IF,ID,EX1..WB); traced RD fields = STAGES-2
//  PC_W         16    PC width
//  INSTR_W      16    instruction width
//  RD_W         4     destination-register index width
//  DEPTH        32    trace entries, power of two, >=4
//  DRAIN_CYCLES 4     cycles captured after halt seen (= STAGES-2 by default)
//  TIMEOUT_CYC  1000  watchdog limit, cycles in CAPTURE before forced DONE
//  TS_W         16    timestamp width; ENTRY_W = TS_W+PC_W+2*INSTR_W+(STAGES-2)*RD_W+3
// PORTS
//  clk        in   1                  clock, rising edge
//  rst_n      in   1                  asynchronous reset, active low
//  trace_en   in   1                  start capture (level, sampled in IDLE)
//  clear      in   1                  sync return to IDLE, empties buffer
//  mode       in   2                  0=WRAP overwrite oldest, 1=STOP_ON_FULL, 2/3 reserved (treated as WRAP)
//  if_pc      in   PC_W               IF-stage PC
//  if_instr   in   INSTR_W            IF-stage instruction
//  id_instr   in   INSTR_W            ID-stage instruction
//  stage_rd   in   (STAGES-2)*RD_W    RD per stage EX1..WB, EX1 in LSBs
//  wb_reg_write in 1                  WB write enable
//  halted     in   1                  CPU halt indication
//  stall      in   1                  hazard stall
//  flush      in   1                  branch flush
//  rd_valid   out  1                  entry available (DONE only)
//  rd_ready   in   1                  pop oldest entry
//  rd_data    out  ENTRY_W            oldest entry {ts,pc,if_instr,id_instr,rds,wb_w,stall,flush}, MSB first
//  count      out  $clog2(DEPTH)+1    entries held
//  full       out  1                  count==DEPTH
//  overflow   out  1                  sticky: WRAP overwrote an entry
//  done       out  1                  in DONE state
//  timeout    out  1                  sticky: DONE reached via watchdog
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, pointers/counters/timestamp 0. Asserts mid-operation abort immediately.
//  - FSM: IDLE -> CAPTURE when trace_en=1. CAPTURE -> DRAIN on halted=1. DRAIN -> DONE after DRAIN_CYCLES.
//    CAPTURE -> DONE with timeout=1 when watchdog reaches TIMEOUT_CYC. DONE -> IDLE only on clear.
//    clear has priority over every transition, in every state.
//  - Capture: one entry per cycle in CAPTURE and DRAIN, including the halt cycle; ts starts at 0 on entry
//    to CAPTURE and wraps modulo 2^TS_W. Stall/flush cycles are captured, not skipped.
//  - Drain: the halt cycle plus DRAIN_CYCLES further writes, then DONE on the following edge.
//    halted re-asserting during DRAIN is ignored.
//  - Halt and watchdog expiry in the same cycle: halt wins; watchdog disabled in DRAIN.
//  - Full, WRAP: write overwrites oldest, rd pointer advances, count stays DEPTH, overflow<=1.
//  - Full, STOP_ON_FULL: writes dropped, FSM keeps running (halt/drain/timeout still tracked), overflow stays 0.
//  - Readout: rd_valid=(state==DONE && count!=0); pop on rd_valid&&rd_ready.
//    rd_data is combinational from the RAM at rd pointer (first-word-fall-through), oldest first.
//    rd_ready ignored outside DONE.
//  - Pointers are log2(DEPTH) bits, wrap naturally. count is one bit wider.
// STRUCTURE
//  - Package ak16_trace_pkg: FSM state enum (IDLE,CAPTURE,DRAIN,DONE), mode encodings, entry field offset localparams.
//  - Sub-module trace_ram: DEPTH x ENTRY_W, 1 sync write port, 1 async read port, no reset on storage.
//  - Top holds FSM, watchdog, drain counter, timestamp, pointers and flags.
// TESTING
//  1. rst_n low for 3 cycles mid-CAPTURE with 5 entries -> count=0, done=0, rd_valid=0; IDLE until trace_en.
//  2. trace_en, halted on ts=9, DRAIN_CYCLES=4 -> 14 entries ts 0..13, done=1 next edge, timeout=0.
//  3. DEPTH=8, WRAP, halt at ts=19 -> count=8, overflow=1, pops yield ts 16..23 in order, then rd_valid=0.
//  4. DEPTH=8, STOP_ON_FULL, halt at ts=19 -> count=8, full=1, overflow=0, pops yield ts 0..7, done=1.
//  5. TIMEOUT_CYC=50, halted held 0 -> done=1 and timeout=1 after cycle 50. Second run: halted and expiry same cycle
//     -> DRAIN, timeout=0.
//  6. In DONE, pop 3 of 14 entries, then clear=1 -> IDLE, count=0, done=0, flags cleared, rd_valid=0.

Source files
------------

// File: rtl/pipe_trace_monitor_pkg.sv
// Shared types for the AK-16 pipeline trace monitor: FSM states, capture modes
// and the fixed low-order field offsets of a trace entry.
package ak16_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } trace_state_e;

   localparam logic [1:0] MODE_WRAP         = 2'd0;
   localparam logic [1:0] MODE_STOP_ON_FULL = 2'd1;

   // Entry layout, LSB first: flush, stall, wb_reg_write, then the per-stage RD fields.
   localparam int FLUSH_OFF = 0;
   localparam int STALL_OFF = 1;
   localparam int WBW_OFF   = 2;
   localparam int RDS_OFF   = 3;

   function automatic int entry_width(int stages, int pc_w, int instr_w, int rd_w, int ts_w);
      return ts_w + pc_w + 2 * instr_w + (stages - 2) * rd_w + 3;
   endfunction

endpackage

// File: rtl/pipe_trace_monitor_if.sv
// Snoop, control, readout and status bundle between the pipeline/host and the monitor.
interface pipe_trace_monitor_if
   import ak16_trace_pkg::*;
#(
   parameter int STAGES  = 6,
   parameter int PC_W    = 16,
   parameter int INSTR_W = 16,
   parameter int RD_W    = 4,
   parameter int DEPTH   = 32,
   parameter int TS_W    = 16
);
   localparam int ENTRY_W = entry_width(STAGES, PC_W, INSTR_W, RD_W, TS_W);
   localparam int CW      = $clog2(DEPTH) + 1;

   logic                         trace_en;
   logic                         clear;
   logic [1:0]                   mode;
   logic [PC_W-1:0]              if_pc;
   logic [INSTR_W-1:0]           if_instr;
   logic [INSTR_W-1:0]           id_instr;
   logic [(STAGES-2)*RD_W-1:0]   stage_rd;
   logic                         wb_reg_write;
   logic                         halted;
   logic                         stall;
   logic                         flush;
   logic                         rd_valid;
   logic                         rd_ready;
   logic [ENTRY_W-1:0]           rd_data;
   logic [CW-1:0]                count;
   logic                         full;
   logic                         overflow;
   logic                         done;
   logic                         timeout;

   modport slave (
      input  trace_en, clear, mode, if_pc, if_instr, id_instr, stage_rd,
             wb_reg_write, halted, stall, flush, rd_ready,
      output rd_valid, rd_data, count, full, overflow, done, timeout
   );

   modport master (
      output trace_en, clear, mode, if_pc, if_instr, id_instr, stage_rd,
             wb_reg_write, halted, stall, flush, rd_ready,
      input  rd_valid, rd_data, count, full, overflow, done, timeout
   );

endinterface

// File: rtl/pipe_trace_monitor_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port, storage not reset.
module trace_ram #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 83
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_trace_monitor.sv
// Pipeline trace/halt monitor: captures one entry per cycle into a circular buffer,
// drains after HALT (or stops on watchdog), then offers the buffer oldest-first.
module pipe_trace_monitor
   import ak16_trace_pkg::*;
#(
   parameter int STAGES       = 6,
   parameter int PC_W         = 16,
   parameter int INSTR_W      = 16,
   parameter int RD_W         = 4,
   parameter int DEPTH        = 32,
   parameter int DRAIN_CYCLES = 4,
   parameter int TIMEOUT_CYC  = 1000,
   parameter int TS_W         = 16
) (
   input  logic clk,
   input  logic rst_n,
   pipe_trace_monitor_if.slave bus
);

   localparam int ENTRY_W = entry_width(STAGES, PC_W, INSTR_W, RD_W, TS_W);
   localparam int AW      = $clog2(DEPTH);
   localparam int CW      = AW + 1;
   localparam int RDS_W   = (STAGES - 2) * RD_W;
   localparam int ID_OFF  = RDS_OFF + RDS_W;
   localparam int IFI_OFF = ID_OFF + INSTR_W;
   localparam int PC_OFF  = IFI_OFF + INSTR_W;
   localparam int TS_OFF  = PC_OFF + PC_W;
   localparam int WD_W    = $clog2(TIMEOUT_CYC + 1);
   localparam int DR_W    = $clog2(DRAIN_CYCLES + 2);

   trace_state_e        state_q, state_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic [TS_W-1:0]     ts_q, ts_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [DR_W-1:0]     drain_q, drain_d;
   logic                overflow_q, overflow_d, timeout_q, timeout_d;
   logic                is_full, capturing, we, pop, rd_valid;
   logic [ENTRY_W-1:0]  wdata, rdata;

   assign is_full   = (count_q == CW'(DEPTH));
   assign capturing = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
   assign we        = capturing && !bus.clear && !(is_full && bus.mode == MODE_STOP_ON_FULL);
   assign rd_valid  = (state_q == ST_DONE) && (count_q != '0);
   assign pop       = rd_valid && bus.rd_ready && !bus.clear;

   always_comb begin
      wdata                      = '0;
      wdata[FLUSH_OFF]           = bus.flush;
      wdata[STALL_OFF]           = bus.stall;
      wdata[WBW_OFF]             = bus.wb_reg_write;
      wdata[RDS_OFF +: RDS_W]    = bus.stage_rd;
      wdata[ID_OFF +: INSTR_W]   = bus.id_instr;
      wdata[IFI_OFF +: INSTR_W]  = bus.if_instr;
      wdata[PC_OFF +: PC_W]      = bus.if_pc;
      wdata[TS_OFF +: TS_W]      = ts_q;
   end

   always_comb begin
      state_d    = state_q;
      timeout_d  = timeout_q;
      overflow_d = overflow_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ts_d       = capturing ? ts_q + TS_W'(1) : '0;
      wd_d       = (state_q == ST_CAPTURE) ? wd_q + WD_W'(1) : '0;
      drain_d    = (state_q == ST_DRAIN) ? drain_q + DR_W'(1) : '0;

      unique case (state_q)
         ST_IDLE: if (bus.trace_en) state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            // Halt is checked first so it wins over a coincident watchdog expiry.
            if (bus.halted) begin
               state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
            end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end
         end
         ST_DRAIN: if (drain_q == DR_W'(DRAIN_CYCLES - 1)) state_d = ST_DONE;
         default: ;
      endcase

      if (we) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (is_full) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            overflow_d = 1'b1;
         end else begin
            count_d = count_q + CW'(1);
         end
      end else if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         count_d  = count_q - CW'(1);
      end

      if (bus.clear) begin
         state_d    = ST_IDLE;
         timeout_d  = 1'b0;
         overflow_d = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         ts_d       = '0;
         wd_d       = '0;
         drain_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ts_q       <= '0;
         wd_q       <= '0;
         drain_q    <= '0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ts_q       <= ts_d;
         wd_q       <= wd_d;
         drain_q    <= drain_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
      end
   end

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_trace_ram (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (wr_ptr_q),
      .wdata_i (wdata),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata)
   );

   // Gate the unreset RAM output so rd_data reads zero whenever nothing is offered.
   assign bus.rd_data  = rd_valid ? rdata : '0;
   assign bus.rd_valid = rd_valid;
   assign bus.count    = count_q;
   assign bus.full     = is_full;
   assign bus.overflow = overflow_q;
   assign bus.done     = (state_q == ST_DONE);
   assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Randomised bench for pipe_trace_monitor: two instances (32 and 8 entries) share one
// stimulus stream and are compared each cycle against a capture-history reference model.
module tb_pipe_trace_monitor;

   localparam int ENTRY_W = 83;
   localparam int DRAIN   = 4;
   localparam int TMO     = 50;
   typedef logic [ENTRY_W-1:0] entry_t;

   logic clk, rst_n;
   logic trace_en, clear, halted, stall, flush, wb_w, rd_ready;
   logic [1:0]  mode;
   logic [15:0] if_pc, if_instr, id_instr, stage_rd;

   int    n_cmp = 0;
   int    n_mis = 0;
   string phase = "init";

   pipe_trace_monitor_if #(.DEPTH(32)) ifa ();
   pipe_trace_monitor_if #(.DEPTH(8))  ifb ();

   pipe_trace_monitor #(.DEPTH(32), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYC(TMO)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa));
   pipe_trace_monitor #(.DEPTH(8), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYC(TMO)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb));

   assign ifa.trace_en = trace_en;      assign ifb.trace_en = trace_en;
   assign ifa.clear = clear;            assign ifb.clear = clear;
   assign ifa.mode = mode;              assign ifb.mode = mode;
   assign ifa.if_pc = if_pc;            assign ifb.if_pc = if_pc;
   assign ifa.if_instr = if_instr;      assign ifb.if_instr = if_instr;
   assign ifa.id_instr = id_instr;      assign ifb.id_instr = id_instr;
   assign ifa.stage_rd = stage_rd;      assign ifb.stage_rd = stage_rd;
   assign ifa.wb_reg_write = wb_w;      assign ifb.wb_reg_write = wb_w;
   assign ifa.halted = halted;          assign ifb.halted = halted;
   assign ifa.stall = stall;            assign ifb.stall = stall;
   assign ifa.flush = flush;            assign ifb.flush = flush;
   assign ifa.rd_ready = rd_ready;      assign ifb.rd_ready = rd_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the full history of this run plus per-instance pop counts;
   // buffer contents follow from the mode (keep newest vs keep first).
   entry_t hist[$];
   int     pops[2];
   bit     m_active, m_done, m_timeout, run_wrap;
   int     m_cyc, m_halt;

   function automatic int depth_of(input int d);
      return (d == 0) ? 32 : 8;
   endfunction

   function automatic int held(input int d);
      int n = hist.size();
      return ((n < depth_of(d)) ? n : depth_of(d)) - pops[d];
   endfunction

   function automatic bit m_ovf(input int d);
      return run_wrap && (hist.size() > depth_of(d));
   endfunction

   function automatic entry_t m_front(input int d);
      int idx = (m_ovf(d) ? hist.size() - depth_of(d) : 0) + pops[d];
      return hist[idx];
   endfunction

   task automatic model_reset();
      hist.delete();
      pops[0] = 0; pops[1] = 0;
      m_active = 0; m_done = 0; m_timeout = 0; m_cyc = 0; m_halt = -1;
   endtask

   task automatic model_edge();
      if (!rst_n || clear) begin
         model_reset();
      end else if (!m_active && !m_done) begin
         if (trace_en) begin
            m_active = 1; m_cyc = 0; m_halt = -1; run_wrap = (mode != 2'd1);
         end
      end else if (m_active) begin
         hist.push_back({m_cyc[15:0], if_pc, if_instr, id_instr, stage_rd, wb_w, stall, flush});
         if (m_halt < 0 && halted) m_halt = m_cyc;
         if (m_halt >= 0 && m_cyc == m_halt + DRAIN) begin
            m_active = 0; m_done = 1;
         end else if (m_halt < 0 && m_cyc == TMO - 1) begin
            m_active = 0; m_done = 1; m_timeout = 1;
         end
         m_cyc++;
      end else begin
         for (int d = 0; d < 2; d++) if (rd_ready && held(d) > 0) pops[d]++;
      end
   endtask

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s [%s] t=%0t got=%0h exp=%0h", tag, phase, $time, got, exp);
      end
   endtask

   task automatic check_dut(input string nm, input int d, input int cnt, input logic full,
                            input logic ovf, input logic dn, input logic to, input logic rv,
                            input entry_t data);
      int h = (m_done || m_active) ? held(d) : 0;
      bit ev = m_done && (h > 0);
      check_eq({nm, ".count"}, cnt, h);
      check_eq({nm, ".full"}, full, h == depth_of(d));
      check_eq({nm, ".overflow"}, ovf, m_ovf(d));
      check_eq({nm, ".done"}, dn, m_done);
      check_eq({nm, ".timeout"}, to, m_timeout);
      check_eq({nm, ".rd_valid"}, rv, ev);
      if (ev) check_eq({nm, ".rd_data"}, data, m_front(d));
      else if (!rst_n) check_eq({nm, ".rd_data_rst"}, data, '0);
   endtask

   task automatic check_both();
      check_dut("A", 0, int'(ifa.count), ifa.full, ifa.overflow, ifa.done, ifa.timeout,
                ifa.rd_valid, ifa.rd_data);
      check_dut("B", 1, int'(ifb.count), ifb.full, ifb.overflow, ifb.done, ifb.timeout,
                ifb.rd_valid, ifb.rd_data);
   endtask

   task automatic rand_fields();
      if_pc    = 16'($urandom);
      if_instr = 16'($urandom);
      id_instr = 16'($urandom);
      stage_rd = 16'($urandom);
      wb_w     = 1'($urandom_range(0, 1));
      stall    = 1'($urandom_range(0, 1));
      flush    = 1'($urandom_range(0, 1));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_both();
      rand_fields();
   endtask

   task automatic run(input string nm, input int halt_at, input int mode_v, input bit noisy_halt,
                      input int npops, input int clear_at);
      phase = nm;
      mode = 2'(mode_v);
      trace_en = 1'b1;
      cycle();
      for (int k = 0; k < 80 && m_active; k++) begin
         trace_en = 1'($urandom_range(0, 1));
         halted   = (k == halt_at) || (noisy_halt && halt_at >= 0 && k > halt_at &&
                                       $urandom_range(0, 1) == 1);
         clear    = (k == clear_at);
         rd_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      trace_en = 1'b0; halted = 1'b0; clear = 1'b0; rd_ready = 1'b0;
      for (int i = 0; i < npops; i++) begin
         rd_ready = 1'b1;
         cycle();
         rd_ready = 1'b0;
         if ($urandom_range(0, 3) == 0) cycle();
      end
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      cycle();
      $display("run %-16s halt_at=%0d mode=%0d pops=%0d clear_at=%0d compared=%0d", nm,
               halt_at, mode_v, npops, clear_at, n_cmp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit [%s] t=%0t", phase, $time);
      $fatal(1, "time limit");
   end

   initial begin
      rst_n = 1'b0; trace_en = 1'b0; clear = 1'b0; halted = 1'b0; rd_ready = 1'b0; mode = 2'd0;
      rand_fields();
      model_reset();
      repeat (3) @(negedge clk);
      phase = "por";
      check_both();
      rst_n = 1'b1;

      // Async reset in the middle of a capture with five entries held.
      phase = "reset_mid";
      trace_en = 1'b1;
      cycle();
      trace_en = 1'b0;
      repeat (5) cycle();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_both();
      trace_en = 1'b1;
      repeat (3) cycle();
      trace_en = 1'b0;
      rst_n = 1'b1;
      repeat (3) cycle();
      $display("run %-16s compared=%0d", phase, n_cmp);

      run("halt9_pop3", 9, 0, 1'b1, 3, -1);
      run("wrap_halt19", 19, 0, 1'b0, 10, -1);
      run("stop_halt19", 19, 1, 1'b0, 10, -1);
      run("timeout", -1, 0, 1'b0, 2, -1);
      run("halt_at_expiry", TMO - 1, 0, 1'b0, 0, -1);
      run("clear_mid", -1, 1, 1'b0, 0, 7);
      for (int r = 0; r < 8; r++) begin
         run("random", int'($urandom_range(0, 50)) - 1, int'($urandom_range(0, 3)), 1'b1,
             int'($urandom_range(0, 40)),
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 30)) : -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
